// File: rtl/tick_window_gen.sv
// Tick-to-window converter: each accepted tick opens a registered enable window of iLEN cycles,
// followed by a GUARD_LEN holdoff and a done pulse. Optional macro: TICK_WINDOW_RETRIGGER_EN.
module tick_window_gen #(
  parameter int CNT_WL    = 8,
  parameter int GUARD_LEN = 2,
  parameter int DROP_WL   = 8
) (
  input  logic               iCLK,
  input  logic               iRSTn,
  input  logic               iTICK,
  input  logic [CNT_WL-1:0]  iLEN,
  input  logic               iCLR,
  output logic               oLEVEL,
  output logic               oDONE,
  output logic               oBUSY,
  output logic [DROP_WL-1:0] oDROP_CNT
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_GUARD  = 2'd2;

  localparam int                  GCNT_WL    = (GUARD_LEN < 2) ? 1 : $clog2(GUARD_LEN + 1);
  localparam logic [GCNT_WL-1:0]  GUARD_LOAD = GCNT_WL'(GUARD_LEN);
  localparam logic [DROP_WL-1:0]  DROP_MAX   = '1;

  logic [1:0]         state_q, state_d;
  logic [CNT_WL-1:0]  cnt_q, cnt_d;
  logic [GCNT_WL-1:0] gcnt_q, gcnt_d;
  logic               level_q, level_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [DROP_WL-1:0] drop_q, drop_d;
  logic               tick_ok;
  logic               drop_inc;

  assign tick_ok = iTICK && (iLEN != '0);

  // NOTE: every signal gets a default at the top so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gcnt_d   = gcnt_q;
    level_d  = level_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    drop_inc = 1'b0;

    if (iCLR) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      gcnt_d  = '0;
      level_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tick_ok) begin
            state_d = ST_ACTIVE;
            cnt_d   = iLEN;
            level_d = 1'b1;
            busy_d  = 1'b1;
          end
        end

        ST_ACTIVE: begin
`ifdef TICK_WINDOW_RETRIGGER_EN
          if (tick_ok) begin
            cnt_d = iLEN;
          end else if (cnt_q <= CNT_WL'(1)) begin
`else
          drop_inc = iTICK;
          if (cnt_q <= CNT_WL'(1)) begin
`endif
            // Last enabled cycle: close the window and enter holdoff (or go straight idle).
            cnt_d   = '0;
            level_d = 1'b0;
            done_d  = 1'b1;
            if (GUARD_LEN != 0) begin
              state_d = ST_GUARD;
              gcnt_d  = GUARD_LOAD;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        ST_GUARD: begin
          drop_inc = iTICK;
          if (gcnt_q <= GCNT_WL'(1)) begin
            state_d = ST_IDLE;
            gcnt_d  = '0;
            busy_d  = 1'b0;
          end else begin
            gcnt_d = gcnt_q - 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          gcnt_d  = '0;
          level_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end

    if (iCLR) begin
      drop_d = '0;
    end else if (drop_inc && (drop_q != DROP_MAX)) begin
      drop_d = drop_q + 1'b1;
    end else begin
      drop_d = drop_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      level_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      level_q <= level_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign oLEVEL    = level_q;
  assign oDONE     = done_q;
  assign oBUSY     = busy_q;
  assign oDROP_CNT = drop_q;

  a_busy_matches_state: assert property (@(posedge iCLK) disable iff (!iRSTn)
    busy_q == (state_q != ST_IDLE));

`ifndef TICK_WINDOW_RETRIGGER_EN
  a_done_level_exclusive: assert property (@(posedge iCLK) disable iff (!iRSTn)
    !(level_q && done_q));
`endif

endmodule

// File: doc/tick_window_gen.md
Name: tick_window_gen

Overview:
- Receive side of the tick interface: consumes one-cycle tick pulses from the tick generators and turns each one into a level-enable window of programmable length.
- Adds a fixed guard/holdoff period after each window and a one-cycle completion pulse.
- Keeps a saturating count of ticks it could not serve.
- Sits between tick sources and datapath blocks that need a held enable (D_REG iEN, accumulator windows).

Parameters:
CNT_WL, 8, width of the window length input and internal down-counter
GUARD_LEN, 2, holdoff cycles after each window during which ticks are rejected; 0 = no guard
DROP_WL, 8, width of the dropped-tick counter

Ports:
iCLK  input  1  clock, all state updates on rising edge
iRSTn  input  1  asynchronous active-low reset
iTICK  input  1  one-cycle tick request, sampled every rising edge
iLEN  input  CNT_WL  window length in cycles, sampled only in the cycle a tick is accepted
iCLR  input  1  synchronous clear
oLEVEL  output  1  registered window enable
oDONE  output  1  one-cycle pulse at window end
oBUSY  output  1  high in ACTIVE or GUARD
oDROP_CNT  output  DROP_WL  saturating count of rejected ticks

Behaviour:
- One clock, iCLK. Reset is asynchronous and active-low on iRSTn.
- Reset values: state=IDLE, oLEVEL=0, oDONE=0, oBUSY=0, oDROP_CNT=0, counter=0. Reset mid-window aborts immediately and produces no oDONE.
- States: IDLE, ACTIVE, GUARD. All outputs are registered.
- IDLE:
  - Tick accepted when iTICK=1 and iLEN!=0.
  - Counter loads iLEN; next state ACTIVE.
  - If the tick is sampled at edge t, oLEVEL=1 for exactly iLEN cycles, t+1 .. t+iLEN (latency 1).
  - iTICK=1 with iLEN=0: ignored. No window, no oDONE, not counted as a drop.
- ACTIVE:
  - Counter decrements each cycle. oLEVEL=1, oBUSY=1.
  - On the last window cycle, the next state is GUARD, or IDLE when GUARD_LEN=0.
  - oDONE=1 for the single cycle t+iLEN+1, the first cycle with oLEVEL=0.
- GUARD:
  - Lasts exactly GUARD_LEN cycles, t+iLEN+1 .. t+iLEN+GUARD_LEN, then IDLE.
  - oLEVEL=0, oBUSY=1.
- First acceptable follow-up tick is sampled at cycle t+iLEN+GUARD_LEN+1. When GUARD_LEN=0 that is cycle t+iLEN+1, and oDONE and the new window start are back-to-back.
- Ticks rejected in ACTIVE (non-retrigger build) or in GUARD increment oDROP_CNT by 1. The counter saturates at all-ones and does not wrap.
- iLEN=all-ones gives a full 2^CNT_WL-1 cycle window. The counter never wraps below 0.
- iCLR=1 (synchronous):
  - Next state IDLE; oLEVEL, oDONE and oBUSY go to 0 next cycle; oDROP_CNT and counter cleared.
  - iCLR has priority over a simultaneous iTICK: that tick is neither accepted nor counted.
- oDONE and oLEVEL are never high in the same cycle, except in retrigger builds (see below).

Optional Feature:
- Macro: TICK_WINDOW_RETRIGGER_EN.
- Defined:
  - A tick with iLEN!=0 sampled in ACTIVE reloads the counter with the new iLEN. oLEVEL stays high through cycles s+1 .. s+iLEN', where s is that tick's sample cycle; oDONE fires only at the final window end.
  - Retriggers are not counted as drops. Ticks with iLEN=0 in ACTIVE are ignored and not counted.
  - Ticks in GUARD are still dropped and counted.
- Undefined:
  - All ticks in ACTIVE are rejected and counted in oDROP_CNT.
  - No reload logic is synthesised.

Test Plan:
1. Reset release, iLEN=4, tick at cycle 10 -> oLEVEL=1 cycles 11-14; oDONE=1 at cycle 15 only; oBUSY=1 cycles 11-16; IDLE at 17.
2. Window iLEN=4 as in 1; extra ticks at cycles 12 and 16 -> no change to window; oDROP_CNT=2 (non-retrigger build); tick at 17 accepted, oLEVEL=1 cycles 18-21.
3. iLEN=0 tick in IDLE -> oLEVEL, oDONE and oDROP_CNT stay 0. Then iLEN=1 -> single-cycle oLEVEL, oDONE the next cycle.
4. iTICK and iCLR high together mid-window -> oLEVEL=0 next cycle, no oDONE, oDROP_CNT=0. Separately, assert iRSTn=0 mid-window -> outputs 0 immediately, without waiting for a clock edge.
5. Force 260 rejected ticks with DROP_WL=8 -> oDROP_CNT holds 255.
6. TICK_WINDOW_RETRIGGER_EN defined: iLEN=4 tick at 10, iLEN=3 tick at 12 -> oLEVEL=1 cycles 11-15; single oDONE at 16; oDROP_CNT=0.
